// File: rtl/data_sc_sched.sv
// ---------------------------------------------------------------------------
// data_sc_sched
//
// Subcarrier scheduler between the receive FFT and the QPSK demapper.
// Takes one 802.16 OFDM symbol as NFFT complex bins in natural FFT order
// (k = 0..NFFT-1). DC, guard and pilot bins are dropped, and the data
// subcarriers go out in bin order. The block also counts complete symbols
// per burst and flags a burst that ends mid-symbol. Both sides use a
// Wishbone-style stream.
//
// Ports
//   CLK_I       in   1      system clock
//   RST_I       in   1      asynchronous reset, active-high
//   DAT_I       in   32     input bin, [31:16]=Im, [15:0]=Re
//   WE_I        in   1      input write strobe
//   STB_I       in   1      input strobe
//   CYC_I       in   1      input burst (cycle) framing
//   ACK_O       out  1      input accept (combinational)
//   DAT_O       out  32     data subcarrier, same packing as DAT_I
//   WE_O        out  1      equals STB_O
//   STB_O       out  1      output strobe
//   CYC_O       out  1      output burst framing
//   ACK_I       in   1      downstream accept
//   SYM_CNT_O   out  SYM_W  complete symbols in the current burst (saturating)
//   SYM_DONE_O  out  1      one-cycle pulse after bin NFFT-1 is accepted
//   ERR_O       out  1      sticky: the last burst ended mid-symbol
// ---------------------------------------------------------------------------
module data_sc_sched #(
  parameter int NFFT       = 256,
  parameter int NUSED_HALF = 100,
  parameter int SYM_W      = 8
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [31:0]      DAT_I,
  input  logic             WE_I,
  input  logic             STB_I,
  input  logic             CYC_I,
  output logic             ACK_O,
  output logic [31:0]      DAT_O,
  output logic             WE_O,
  output logic             STB_O,
  output logic             CYC_O,
  input  logic             ACK_I,
  output logic [SYM_W-1:0] SYM_CNT_O,
  output logic             SYM_DONE_O,
  output logic             ERR_O
);

  localparam int KW = $clog2(NFFT);

  // Guard band: the unused bins between the positive and negative halves.
  localparam logic [KW-1:0] GUARD_LO = KW'(NUSED_HALF + 1);
  localparam logic [KW-1:0] GUARD_HI = KW'(NFFT - NUSED_HALF - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NFFT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic          out_halt;
  logic          ena;
  logic          is_pilot;
  logic          is_data;

  // The output register is stalled while an offered beat is still waiting
  // for downstream acceptance.
  assign out_halt = STB_O & ~ACK_I;
  assign ena      = CYC_I & STB_I & WE_I;

  // The input stalls in DRAIN, so a new burst cannot start before the old one
  // has fully left. Gating with RST_I keeps ACK_O at 0 during reset even
  // though the handshake is combinational.
  assign ACK_O = ena & ~out_halt & (state != DRAIN) & ~RST_I;

  assign WE_O = STB_O;

  // Pilot positions of the 256-point 802.16 OFDM symbol.
  assign is_pilot = (k == KW'(13))  || (k == KW'(38))  ||
                    (k == KW'(63))  || (k == KW'(88))  ||
                    (k == KW'(168)) || (k == KW'(193)) ||
                    (k == KW'(218)) || (k == KW'(243));

  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    is_data = 1'b1;
    if (k == '0)                          is_data = 1'b0;  // DC
    else if (k >= GUARD_LO && k <= GUARD_HI) is_data = 1'b0;  // guard band
    else if (is_pilot)                    is_data = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this clock edge.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state      <= IDLE;
      k          <= '0;
      DAT_O      <= '0;
      STB_O      <= 1'b0;
      CYC_O      <= 1'b0;
      SYM_CNT_O  <= '0;
      SYM_DONE_O <= 1'b0;
      ERR_O      <= 1'b0;
    end else begin
      SYM_DONE_O <= 1'b0;

      // Output register: load a new beat (or bubble) only when not halted.
      if (!out_halt) begin
        STB_O <= ACK_O & is_data;
        if (ACK_O && is_data) begin
          DAT_O <= DAT_I;
          CYC_O <= 1'b1;
        end
      end

      // Every accepted bin advances the index, whether forwarded or dropped.
      if (ACK_O) begin
        k <= k + 1'b1;
        if (k == K_LAST) begin
          SYM_DONE_O <= 1'b1;
          if (SYM_CNT_O != '1) SYM_CNT_O <= SYM_CNT_O + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          // The first bin is accepted in this same cycle.
          if (ACK_O) begin
            state <= RUN;
            ERR_O <= 1'b0;
          end
        end
        RUN: begin
          // ACK_O is 0 here because CYC_I is low, so overriding k is safe.
          if (!CYC_I) begin
            state <= DRAIN;
            k     <= '0;
            if (k != '0) ERR_O <= 1'b1;
          end
        end
        DRAIN: begin
          if (!STB_O) begin
            state     <= IDLE;
            CYC_O     <= 1'b0;
            SYM_CNT_O <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sc_sched.sv
// ---------------------------------------------------------------------------
// tb_data_sc_sched
//
// Randomized self-checking bench for data_sc_sched. Each burst is a list of
// bins whose low half is the bin index. The expected output stream comes from
// the subcarrier classification rules, applied to that list. Observed beats
// (STB_O & ACK_I) are compared in order against the expected stream. Symbol
// counts, SYM_DONE_O pulses, ERR_O, CYC_O fall and asynchronous reset are
// checked as well.
// ---------------------------------------------------------------------------
module tb_data_sc_sched;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [31:0] DAT_I;
  logic        WE_I;
  logic        STB_I;
  logic        CYC_I;
  logic        ACK_O;
  logic [31:0] DAT_O;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic        ACK_I;
  logic [7:0]  SYM_CNT_O;
  logic        SYM_DONE_O;
  logic        ERR_O;

  data_sc_sched #(.NFFT(256), .NUSED_HALF(100), .SYM_W(8)) dut (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .DAT_I      (DAT_I),
    .WE_I       (WE_I),
    .STB_I      (STB_I),
    .CYC_I      (CYC_I),
    .ACK_O      (ACK_O),
    .DAT_O      (DAT_O),
    .WE_O       (WE_O),
    .STB_O      (STB_O),
    .CYC_O      (CYC_O),
    .ACK_I      (ACK_I),
    .SYM_CNT_O  (SYM_CNT_O),
    .SYM_DONE_O (SYM_DONE_O),
    .ERR_O      (ERR_O)
  );

  always #5 CLK_I = ~CLK_I;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] burst_data[$];
  logic [31:0] exp_q[$];
  int          idx;
  int          beats;
  int          done_cnt;
  int          ack_mode;
  int          cyc_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference classification: data = 1..100 and 156..255, minus the pilots.
  function automatic bit is_data_ref(int k);
    if (k == 0) return 1'b0;
    if (k > 100 && k < 156) return 1'b0;
    if (k inside {13, 38, 63, 88, 168, 193, 218, 243}) return 1'b0;
    return 1'b1;
  endfunction

  // One clock cycle. Inputs are driven at the falling edge. ACK_O and the
  // outputs are sampled 1 ns later, well before the next rising edge.
  task automatic step(input bit want_stb, input bit cyc);
    @(negedge CLK_I);
    CYC_I = cyc;
    STB_I = want_stb && (idx < burst_data.size()) && ($urandom_range(3) != 0);
    WE_I  = STB_I ? ($urandom_range(7) != 0) : 1'($urandom_range(1));
    DAT_I = STB_I ? burst_data[idx] : $urandom;
    case (ack_mode)
      0:       ACK_I = 1'b1;
      1:       ACK_I = (cyc_n % 3 == 0);
      default: ACK_I = 1'($urandom_range(1));
    endcase
    cyc_n++;
    #1;
    if (STB_O && !ACK_I) check("ack_during_halt", ACK_O, 0);
    if (STB_O && ACK_I) begin
      if (exp_q.size() == 0) check("extra_beat", DAT_O, 32'hxxxx_xxxx);
      else                   check("beat", DAT_O, exp_q.pop_front());
      beats++;
    end
    if (SYM_DONE_O) done_cnt++;
    if (ACK_O) idx++;
  endtask

  task automatic prepare(input int n);
    int k;
    burst_data.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      k = i % 256;
      burst_data.push_back({16'($urandom), 16'(k)});
      if (is_data_ref(k)) exp_q.push_back(burst_data[i]);
    end
    idx      = 0;
    beats    = 0;
    done_cnt = 0;
  endtask

  task automatic run_burst(input int n, input int mode);
    int n_exp;
    ack_mode = mode;
    prepare(n);
    n_exp = exp_q.size();
    for (int c = 0; c < 20000 && idx < n; c++) step(1'b1, 1'b1);
    check("bins_fed", idx, n);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("sym_cnt_in_burst", SYM_CNT_O, n / 256);
    check("err_clear_in_burst", ERR_O, 0);
    for (int c = 0; c < 2000; c++) begin
      step(1'b0, 1'b0);
      if (!CYC_O && !STB_O) break;
    end
    check("cyc_o_fall", CYC_O, 0);
    check("beat_count", beats, n_exp);
    check("sym_done_pulses", done_cnt, n / 256);
    check("err_after_burst", ERR_O, (n % 256) != 0);
    check("sym_cnt_idle", SYM_CNT_O, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},  ACK_O, 0);
    check({tag, "_dat"},  DAT_O, 0);
    check({tag, "_we"},   WE_O, 0);
    check({tag, "_stb"},  STB_O, 0);
    check({tag, "_cyc"},  CYC_O, 0);
    check({tag, "_cnt"},  SYM_CNT_O, 0);
    check({tag, "_done"}, SYM_DONE_O, 0);
    check({tag, "_err"},  ERR_O, 0);
  endtask

  initial begin
    RST_I = 1'b1;
    DAT_I = '0;
    WE_I  = 1'b0;
    STB_I = 1'b0;
    CYC_I = 1'b0;
    ACK_I = 1'b0;
    idx   = 0;
    beats = 0;
    done_cnt = 0;
    ack_mode = 0;
    #3;
    check_all_zero("reset");
    @(negedge CLK_I);
    @(negedge CLK_I);
    RST_I = 1'b0;

    run_burst(256, 0);   // single symbol, ACK_I high
    run_burst(256, 1);   // backpressure: ACK_I high 1 cycle in 3
    run_burst(768, 2);   // three back-to-back symbols, random ACK_I
    run_burst(120, 0);   // truncated burst
    run_burst(256, 2);   // next burst clears ERR_O and starts at k = 0

    // Asynchronous reset asserted at bin 150, between clock edges.
    ack_mode = 0;
    prepare(256);
    for (int c = 0; c < 5000 && idx < 150; c++) step(1'b1, 1'b1);
    check("bins_before_reset", idx, 150);
    #1;
    RST_I = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge CLK_I);
    CYC_I = 1'b0;
    STB_I = 1'b0;
    @(negedge CLK_I);
    RST_I = 1'b0;
    exp_q.delete();

    run_burst(256, 2);   // recovery after reset

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_sc_sched.md
Name: data_sc_sched

Overview:
- Subcarrier scheduler placed between the receive FFT output and the QPSK data-symbol demapper.
- Accepts one 802.16 OFDM symbol as 256 complex bins in natural FFT order, indexed k = 0..255.
- Discards DC, guard and pilot bins, so only the 192 data subcarriers reach the demapper, in bin order.
- Counts symbols per burst and flags truncated symbols. Wishbone-style stream on both sides.

Parameters:
- NFFT, 256, bins per OFDM symbol.
- NUSED_HALF, 100, used bins on each side of DC.
- SYM_W, 8, width of the symbol counter.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  asynchronous reset, active-high
- DAT_I  in  32  input bin, [31:16]=Im, [15:0]=Re
- WE_I, STB_I, CYC_I  in  1 each  input bus strobes
- ACK_O  out  1  input accept
- DAT_O  out  32  data subcarrier to the demapper, same packing as DAT_I
- WE_O  out  1  equals STB_O
- STB_O, CYC_O  out  1 each  output bus strobes
- ACK_I  in  1  downstream accept
- SYM_CNT_O  out  SYM_W  number of complete symbols in the current burst
- SYM_DONE_O  out  1  one-cycle pulse when bin 255 is accepted
- ERR_O  out  1  sticky flag: burst ended mid-symbol

Behaviour:
- Reset: CLK_I is the single clock; RST_I is asynchronous and active-high. While RST_I is high, every output, the bin index k and the state register are 0, and state = IDLE.
- Handshake:
  - out_halt = STB_O & ~ACK_I.
  - ena = CYC_I & STB_I & WE_I.
  - ACK_O = ena & ~out_halt (combinational).
  - An input bin is consumed on every cycle where ACK_O = 1, whether it is forwarded or dropped.
- Bin classification for the k of the accepted bin:
  - DC: k = 0.
  - Guard: NUSED_HALF+1 <= k <= NFFT-NUSED_HALF-1, i.e. 101..155.
  - Pilot: k in {13, 38, 63, 88, 168, 193, 218, 243}.
  - Data: every other bin. This gives 1..100 minus 4 pilots, then 156..255 minus 4 pilots = 192 bins.
- Output register:
  - When ~out_halt: DAT_O is loaded with DAT_I on an accepted data bin, and STB_O = (ACK_O & is_data).
  - When out_halt: DAT_O and STB_O hold.
  - Latency is 1 cycle from ACK_O to STB_O.
  - DAT_O is passed through unmodified, with no scaling.
- Index counter:
  - k increments on each ACK_O and wraps 255 -> 0.
  - On wrap, SYM_DONE_O pulses for 1 cycle and SYM_CNT_O increments, saturating at all-ones.
- State machine:
  - IDLE: k = 0, SYM_CNT_O = 0. Move to RUN when ena is high; this first bin is accepted in the same cycle. ERR_O clears on this transition.
  - RUN: CYC_O is set on the first cycle STB_O is loaded high. When CYC_I falls, move to DRAIN. If k != 0 at that point, set ERR_O and force k to 0. The partial symbol is not counted.
  - DRAIN: ACK_O is forced low. Wait until STB_O = 0 (the last output has been accepted), then clear CYC_O and return to IDLE.
- CYC_I rising again while in DRAIN is ignored until IDLE is reached. The input stalls via ACK_O = 0 and no bins are lost.
- STB_I low in RUN: no accept; k and all outputs hold, apart from normal output draining.
- ACK_I high while STB_O is low has no effect.
- Back-to-back symbols need no gap: bin 0 of symbol n+1 may be accepted in the cycle after bin 255 of symbol n.
- Reset asserted mid-symbol: all state is cleared at once and no partial output completes.

Test Plan:
- Reset/idle: RST_I pulse with CYC_I = 0 -> all outputs 0; ACK_O = 0.
- One symbol, ACK_I tied high: feed 256 bins with DAT_I = {16'hk, 16'hk} -> exactly 192 STB_O beats.
  - First DAT_O low half = 1, and 13 is absent.
  - Last two beats are 254 and 255, and 243 is absent.
  - SYM_DONE_O pulses once; SYM_CNT_O = 1.
- Backpressure: same stimulus with ACK_I high on 1 cycle in every 3 -> the same 192-value sequence, with none dropped or duplicated. ACK_O is low on every cycle where STB_O = 1 and ACK_I = 0.
- Three back-to-back symbols, then CYC_I low -> 576 beats; SYM_CNT_O = 3; CYC_O falls after the last beat is acknowledged; ERR_O = 0.
- Truncated burst: CYC_I drops after 120 bins -> 96 beats (data bins 1..100 minus 4 pilots); ERR_O = 1; SYM_CNT_O = 0. The next burst clears ERR_O and starts at k = 0.
- Async reset with RST_I asserted at bin 150 -> all outputs 0 within the same cycle, without waiting for a clock edge.
